folded_neuron: RTL and testbench

FOLDED_NEURON -- requirements
Module: folded_neuron

---
 rtl/neuron_pkg.sv | 21 ++
 rtl/folded_neuron_if.sv | 25 ++
 rtl/neuron_act.sv | 52 +++++
 rtl/folded_neuron.sv | 130 +++++++++++++
 tb/tb_folded_neuron.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_pkg.sv
// Shared types and sizing helpers for the folded neuron: FSM state encoding,
// fixed-point fraction width and accumulator width.
package neuron_pkg;

  typedef enum logic [1:0] {StIdle, StMac, StAct, StOut} state_e;

  function automatic int unsigned frac_bits(input int unsigned width);
    case (width)
      8:       return 5;
      16:      return 10;
      32:      return 20;
      default: return width / 2;
    endcase
  endfunction

  // Wide enough to hold the shifted bias plus N full-scale products without wrap.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned n);
    return 2 * width + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/folded_neuron_if.sv
// Operand/result handshake bundle of the folded neuron. The master side drives
// operands and out_ready; the slave side (the neuron) drives the rest.
interface folded_neuron_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x_in [N+1];
  logic signed [WIDTH-1:0] w_in [N];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] result;
  logic                    busy;

  modport master (
    output in_valid, x_in, w_in, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, x_in, w_in, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/neuron_act.sv
// Saturation of the accumulator to WIDTH bits followed by the activation.
// NEURON_SIGMOID_EN selects a hard sigmoid; otherwise ReLU is built.
module neuron_act #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 5,
  parameter int unsigned AccW  = 2 * WIDTH + 3
) (
  input  logic signed [AccW-1:0]  acc_i,
  output logic signed [WIDTH-1:0] y_o
);

  typedef logic signed [AccW-1:0]  acc_t;
  typedef logic signed [WIDTH-1:0] dat_t;

  acc_t s_full;
  dat_t s_sat;

  // In range iff every bit above the target sign bit matches it.
  always_comb begin
    s_full = acc_i >>> FRAC;
    if ((&s_full[AccW-1:WIDTH-1]) || (~|s_full[AccW-1:WIDTH-1])) begin
      s_sat = s_full[WIDTH-1:0];
    end else if (s_full[AccW-1]) begin
      s_sat = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      s_sat = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

`ifdef NEURON_SIGMOID_EN
  typedef logic signed [WIDTH+1:0] sig_t;

  localparam sig_t One  = sig_t'(1) <<< FRAC;
  localparam sig_t Half = sig_t'(1) <<< (FRAC - 1);

  sig_t t;

  always_comb begin
    t = Half + (sig_t'(s_sat) >>> 2);
    if (t < 0) begin
      y_o = '0;
    end else if (t > One) begin
      y_o = WIDTH'(One);
    end else begin
      y_o = WIDTH'(t);
    end
  end
`else
  always_comb y_o = s_sat[WIDTH-1] ? '0 : s_sat;
`endif

endmodule

// File: rtl/folded_neuron.sv
// Folded single neuron: bias + N weighted inputs accumulated P products per
// cycle, then saturated and activated (NEURON_SIGMOID_EN selects the activation).
module folded_neuron
  import neuron_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned P     = 1
) (
  input logic          clk,
  input logic          rst_n,
  folded_neuron_if.slave bus_io
);

  localparam int unsigned FRAC  = frac_bits(WIDTH);
  localparam int unsigned AccW  = acc_width(WIDTH, N);
  localparam int unsigned Steps = N / P;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

  if ((N % P) != 0) begin : g_bad_lanes
    $error("folded_neuron: N must be a multiple of P");
  end

  typedef logic signed [AccW-1:0]    acc_t;
  typedef logic signed [2*WIDTH-1:0] prod_t;
  typedef logic signed [WIDTH-1:0]   dat_t;
  typedef logic [CntW-1:0]           cnt_t;

  localparam cnt_t LastCnt = cnt_t'(Steps - 1);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  acc_t   acc_q, acc_d;
  dat_t   x_q [N];
  dat_t   x_d [N];
  dat_t   w_q [N];
  dat_t   w_d [N];
  dat_t   res_q, res_d;
  logic   ovld_q, ovld_d;

  acc_t   mac_sum;
  dat_t   act_y;

  // Products whose index falls in the current lane group; the rest contribute zero.
  always_comb begin
    mac_sum = '0;
    for (int k = 0; k < N; k++) begin
      if ((k / int'(P)) == int'(cnt_q)) begin
        mac_sum = mac_sum + acc_t'(prod_t'(w_q[k]) * prod_t'(x_q[k]));
      end
    end
  end

  neuron_act #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .AccW  (AccW)
  ) u_act (
    .acc_i (acc_q),
    .y_o   (act_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    w_d     = w_q;
    res_d   = res_q;
    ovld_d  = ovld_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          for (int i = 0; i < N; i++) begin
            x_d[i] = bus_io.x_in[i+1];
            w_d[i] = bus_io.w_in[i];
          end
          acc_d   = acc_t'(bus_io.x_in[0]) <<< FRAC;
          cnt_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + mac_sum;
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == LastCnt) begin
          state_d = StAct;
        end
      end
      StAct: begin
        res_d   = act_y;
        ovld_d  = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        if (bus_io.out_ready) begin
          ovld_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '{default: '0};
      w_q     <= '{default: '0};
      res_q   <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      w_q     <= w_d;
      res_q   <= res_d;
      ovld_q  <= ovld_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.out_valid = ovld_q;
  assign bus_io.result    = res_q;

endmodule

// File: tb/tb_folded_neuron.sv
// Bench for folded_neuron: a P=1 and a P=2 instance share stimulus and are
// compared against an arithmetic model of the neuron (honours NEURON_SIGMOID_EN).
module tb_folded_neuron;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  folded_neuron_if #(.N(N), .WIDTH(W)) if_p1 ();
  folded_neuron_if #(.N(N), .WIDTH(W)) if_p2 ();

  folded_neuron #(.N(N), .WIDTH(W), .P(1)) u_p1 (.clk(clk), .rst_n(rst_n), .bus_io(if_p1));
  folded_neuron #(.N(N), .WIDTH(W), .P(2)) u_p2 (.clk(clk), .rst_n(rst_n), .bus_io(if_p2));

  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] x_drv [N+1];
  logic signed [W-1:0] w_drv [N];

  assign if_p1.in_valid  = in_valid;
  assign if_p2.in_valid  = in_valid;
  assign if_p1.out_ready = out_ready;
  assign if_p2.out_ready = out_ready;
  assign if_p1.x_in      = x_drv;
  assign if_p2.x_in      = x_drv;
  assign if_p1.w_in      = w_drv;
  assign if_p2.w_in      = w_drv;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Real-valued neuron in units of 1/32, then saturation and activation.
  function automatic longint model(input longint xv[5], input longint wv[4]);
    longint a;
    longint s;
    longint y;
    a = xv[0] * 32;
    for (int i = 0; i < 4; i++) a = a + wv[i] * xv[i+1];
    s = fdiv(a, 32);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`ifdef NEURON_SIGMOID_EN
    y = 16 + fdiv(s, 4);
    if (y < 0) y = 0;
    if (y > 32) y = 32;
`else
    y = (s < 0) ? 0 : s;
`endif
    return y;
  endfunction

  function automatic longint rnd_val();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return 127;
    if (sel == 1) return -128;
    return longint'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(if_p1.in_ready && if_p2.in_ready) && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("idle_ready", {if_p1.in_ready, if_p2.in_ready}, 2'b11);
  endtask

  task automatic apply(input longint xv[5], input longint wv[4]);
    for (int i = 0; i <= 4; i++) x_drv[i] = W'(xv[i]);
    for (int i = 0; i < 4; i++) w_drv[i] = W'(wv[i]);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands changing after accept must not disturb the computation.
    for (int i = 0; i <= 4; i++) x_drv[i] = W'($urandom);
    for (int i = 0; i < 4; i++) w_drv[i] = W'($urandom);
  endtask

  task automatic run_op(input string name, input longint xv[5], input longint wv[4], input int bp);
    longint exp;
    int     lat1;
    int     lat2;
    int     busy_bad;
    exp = model(xv, wv);
    wait_idle();
    apply(xv, wv);
    lat1 = -1;
    lat2 = -1;
    busy_bad = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (lat1 < 0 && if_p1.out_valid) lat1 = e;
      if (lat2 < 0 && if_p2.out_valid) lat2 = e;
      if (!if_p1.busy || !if_p2.busy) busy_bad++;
      if (lat1 >= 0 && lat2 >= 0) break;
    end
    check_eq({name, "_lat_p1"}, lat1, 5);
    check_eq({name, "_lat_p2"}, lat2, 3);
    check_eq({name, "_busy"}, busy_bad, 0);
    check_eq({name, "_res_p1"}, longint'(if_p1.result), exp);
    check_eq({name, "_res_p2"}, longint'(if_p2.result), exp);
    for (int c = 0; c < bp; c++) begin
      @(posedge clk);
      #1;
      check_eq({name, "_hold_res_p1"}, longint'(if_p1.result), exp);
      check_eq({name, "_hold_res_p2"}, longint'(if_p2.result), exp);
    end
    check_eq({name, "_pre_hs_flags"},
             {if_p1.out_valid, if_p2.out_valid, if_p1.in_ready, if_p2.in_ready}, 4'b1100);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({name, "_post_hs_flags"},
             {if_p1.out_valid, if_p2.out_valid, if_p1.in_ready, if_p2.in_ready}, 4'b0011);
  endtask

  task automatic reset_mid_mac();
    longint xv[5];
    longint wv[4];
    int     seen;
    xv = '{0, 32, 32, 32, 32};
    wv = '{32, 32, 32, 32};
    wait_idle();
    apply(xv, wv);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_async",
             {if_p1.out_valid, if_p2.out_valid, if_p1.busy, if_p2.busy}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (if_p1.out_valid || if_p2.out_valid) seen++;
    end
    check_eq("rst_mid_no_valid", seen, 0);
    check_eq("rst_mid_res_p1", longint'(if_p1.result), 0);
    check_eq("rst_mid_res_p2", longint'(if_p2.result), 0);
    check_eq("rst_mid_ready", {if_p1.in_ready, if_p2.in_ready}, 2'b11);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    longint xv[5];
    longint wv[4];
    for (int i = 0; i <= 4; i++) x_drv[i] = '0;
    for (int i = 0; i < 4; i++) w_drv[i] = '0;
    #3;
    check_eq("reset_flags",
             {if_p1.out_valid, if_p2.out_valid, if_p1.busy, if_p2.busy}, 4'b0000);
    check_eq("reset_res_p1", longint'(if_p1.result), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("reset_ready", {if_p1.in_ready, if_p2.in_ready}, 2'b11);

    xv = '{0, 32, 32, 32, 32};
    wv = '{32, 32, 32, 32};
    run_op("overflow", xv, wv, 6);

    xv = '{16, 32, 0, 0, 0};
    wv = '{16, 0, 0, 0};
    run_op("mixed", xv, wv, 0);

    xv = '{-128, rnd_val(), rnd_val(), rnd_val(), rnd_val()};
    wv = '{0, 0, 0, 0};
    run_op("negative", xv, wv, 1);

    xv = '{0, 0, 0, 0, 0};
    wv = '{0, 0, 0, 0};
    run_op("zeros", xv, wv, 0);

    reset_mid_mac();

    xv = '{16, 32, 0, 0, 0};
    wv = '{16, 0, 0, 0};
    run_op("after_rst", xv, wv, 2);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i <= 4; i++) xv[i] = rnd_val();
      for (int i = 0; i < 4; i++) wv[i] = rnd_val();
      run_op("rand", xv, wv, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
